// File: rtl/weight_buffer_pkg.sv
// -----------------------------------------------------------------------------
// weight_buffer_pkg
// Shared constants and types for the ping-pong weight buffer.
//   WB_NUM_BANKS  : number of banks (ping/pong)
//   WB_BANK_W     : bank-select width (MSB of the RAM address)
//   WB_B_ADDR_DEF : default per-bank address width
//   WB_RD_LAT     : read latency in cycles; 2 when WEIGHT_BUFFER_DOREG_EN is
//                   defined (extra output register), otherwise 1
//   wb_len_t      : length field for the default address width
// -----------------------------------------------------------------------------
package weight_buffer_pkg;

    localparam int WB_NUM_BANKS  = 2;
    localparam int WB_BANK_W     = $clog2(WB_NUM_BANKS);
    localparam int WB_B_ADDR_DEF = 9;

`ifdef WEIGHT_BUFFER_DOREG_EN
    localparam int WB_RD_LAT = 2;
`else
    localparam int WB_RD_LAT = 1;
`endif

    typedef logic [WB_B_ADDR_DEF:0] wb_len_t;

endpackage

// File: rtl/wb_sdp_ram.sv
// -----------------------------------------------------------------------------
// wb_sdp_ram
// Simple-dual-port RAM with per-byte write enables and a registered read port.
// Ports:
//   clk_i    : clock
//   rst_n_i  : async active-low reset (read-data register only; array is not cleared)
//   we_i     : write enable
//   waddr_i  : write address
//   wdata_i  : write data
//   wstrb_i  : per-byte write enable
//   re_i     : read enable; rdata_o updates next cycle, otherwise holds
//   raddr_i  : read address
//   rdata_o  : registered read data
// -----------------------------------------------------------------------------
module wb_sdp_ram #(
    parameter int AW = 10,
    parameter int DW = 64,
    parameter int SW = DW / 8
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [SW-1:0] wstrb_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [2**AW];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int i = 0; i < SW; i++) begin
                if (wstrb_i[i]) begin
                    mem_q[waddr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/weight_buffer_pp.sv
// -----------------------------------------------------------------------------
// weight_buffer_pp
// Ping-pong weight buffer: the loader fills one bank while the MAC array reads
// the other; banks change hands through commit (wr_last) / release (rd_last).
// Optional build macro: WEIGHT_BUFFER_DOREG_EN adds an output register stage
// (read latency 2 instead of 1); handshake timing is unchanged.
// Ports:
//   clk, rstn           : clock, async active-low reset
//   wr_ready            : current write bank is free
//   we/wraddr/di/wstrb  : write strobe, word address, data, byte enables
//   wr_last             : commit the write bank with this write
//   rd_avail, rd_len    : current read bank is committed / its write count
//   rden/rdaddr         : read strobe and word address
//   rd_last             : release the read bank with this read
//   dout, dout_valid    : read data and its valid pulse
//   bank_full           : per-bank committed flags
// -----------------------------------------------------------------------------
module weight_buffer_pp
    import weight_buffer_pkg::*;
#(
    parameter  int B_ADDR = WB_B_ADDR_DEF,
    parameter  int B_DATA = 64,
    localparam int B_STRB = B_DATA / 8
) (
    input  logic              clk,
    input  logic              rstn,
    output logic              wr_ready,
    input  logic              we,
    input  logic [B_ADDR-1:0] wraddr,
    input  logic [B_DATA-1:0] di,
    input  logic [B_STRB-1:0] wstrb,
    input  logic              wr_last,
    output logic              rd_avail,
    output logic [B_ADDR:0]   rd_len,
    input  logic              rden,
    input  logic [B_ADDR-1:0] rdaddr,
    input  logic              rd_last,
    output logic [B_DATA-1:0] dout,
    output logic              dout_valid,
    output logic [1:0]        bank_full
);

    localparam logic [B_ADDR:0] LEN_ONE = 1;
    localparam logic [B_ADDR:0] DEPTH   = LEN_ONE << B_ADDR;

    logic [1:0]        bank_full_q, bank_full_d;
    logic              wr_sel_q, wr_sel_d;
    logic              rd_sel_q, rd_sel_d;
    logic [B_ADDR:0]   wcnt_q, wcnt_d;
    logic [B_ADDR:0]   len0_q, len0_d;
    logic [B_ADDR:0]   len1_q, len1_d;
    logic [B_ADDR:0]   wcnt_inc;
    logic              wr_acc, rd_acc, commit, rel;
    logic              vld_p1_q;
    logic [B_DATA-1:0] ram_rdata;

    assign wr_ready  = ~bank_full_q[wr_sel_q];
    assign rd_avail  = bank_full_q[rd_sel_q];
    assign rd_len    = rd_sel_q ? len1_q : len0_q;
    assign bank_full = bank_full_q;

    assign wr_acc = we & wr_ready;
    assign rd_acc = rden & rd_avail;
    assign commit = wr_acc & wr_last;
    assign rel    = rd_acc & rd_last;

    // Commit needs an empty bank and release needs a full one, so the two can
    // never hit the same bank in one cycle; applying both updates is safe.
    always_comb begin
        bank_full_d = bank_full_q;
        wr_sel_d    = wr_sel_q;
        rd_sel_d    = rd_sel_q;
        wcnt_d      = wcnt_q;
        len0_d      = len0_q;
        len1_d      = len1_q;
        wcnt_inc    = (wcnt_q == DEPTH) ? wcnt_q : wcnt_q + LEN_ONE;

        if (wr_acc) begin
            wcnt_d = wcnt_inc;
        end
        if (commit) begin
            bank_full_d[wr_sel_q] = 1'b1;
            wr_sel_d              = ~wr_sel_q;
            wcnt_d                = '0;
            if (wr_sel_q) begin
                len1_d = wcnt_inc;
            end else begin
                len0_d = wcnt_inc;
            end
        end
        if (rel) begin
            bank_full_d[rd_sel_q] = 1'b0;
            rd_sel_d              = ~rd_sel_q;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bank_full_q <= '0;
            wr_sel_q    <= 1'b0;
            rd_sel_q    <= 1'b0;
            wcnt_q      <= '0;
            len0_q      <= '0;
            len1_q      <= '0;
            vld_p1_q    <= 1'b0;
        end else begin
            bank_full_q <= bank_full_d;
            wr_sel_q    <= wr_sel_d;
            rd_sel_q    <= rd_sel_d;
            wcnt_q      <= wcnt_d;
            len0_q      <= len0_d;
            len1_q      <= len1_d;
            vld_p1_q    <= rd_acc;
        end
    end

    // Bank select is the RAM address MSB; the writer and reader always sit on
    // different banks while both are active, so no same-word collision occurs.
    wb_sdp_ram #(
        .AW (B_ADDR + WB_BANK_W),
        .DW (B_DATA),
        .SW (B_STRB)
    ) u_ram (
        .clk_i   (clk),
        .rst_n_i (rstn),
        .we_i    (wr_acc),
        .waddr_i ({wr_sel_q, wraddr}),
        .wdata_i (di),
        .wstrb_i (wstrb),
        .re_i    (rd_acc),
        .raddr_i ({rd_sel_q, rdaddr}),
        .rdata_o (ram_rdata)
    );

`ifdef WEIGHT_BUFFER_DOREG_EN
    // ---- stage p2: optional output register ----
    logic [B_DATA-1:0] dout_p2_q;
    logic              vld_p2_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dout_p2_q <= '0;
            vld_p2_q  <= 1'b0;
        end else begin
            vld_p2_q <= vld_p1_q;
            if (vld_p1_q) begin
                dout_p2_q <= ram_rdata;
            end
        end
    end

    assign dout       = dout_p2_q;
    assign dout_valid = vld_p2_q;
`else
    assign dout       = ram_rdata;
    assign dout_valid = vld_p1_q;
`endif

endmodule
